// File: rtl/fetch_pc_predict_pkg.sv
// fetch_pc_predict_pkg: shared constants and pipeline-entry record for the fetch predictor
package fetch_pc_predict_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] pred_tgt;
  } pipe_entry_t;
endpackage

// File: rtl/fetch_pc_predict_if.sv
// fetch_pc_predict_if: branch-table lookup, s4 resolution and statistics signals
interface fetch_pc_predict_if #(parameter int CNT_W = 16);
  logic             stall;
  logic [31:0]      inst_adress_s1;
  logic [31:0]      b_dest_out;
  logic             p_s1;
  logic             hit_s1;
  logic             is_branch_s4;
  logic             taken_s4;
  logic [31:0]      target_s4;
  logic             write_rp;
  logic             write_rt;
  logic             deviated_s4;
  logic [31:0]      b_dest_in;
  logic [31:0]      inst_adress_s4;
  logic             flush;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  modport master (
    output stall, b_dest_out, p_s1, hit_s1, is_branch_s4, taken_s4, target_s4,
    input  inst_adress_s1, write_rp, write_rt, deviated_s4, b_dest_in, inst_adress_s4, flush,
           branch_cnt, mispred_cnt
  );
  modport slave (
    input  stall, b_dest_out, p_s1, hit_s1, is_branch_s4, taken_s4, target_s4,
    output inst_adress_s1, write_rp, write_rt, deviated_s4, b_dest_in, inst_adress_s4, flush,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/fetch_pc_predict_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/fetch_pc_predict.sv
// fetch_pc_predict: next-PC selection with branch-table prediction and s4 mispredict recovery
module fetch_pc_predict
  import fetch_pc_predict_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  fetch_pc_predict_if.slave bus
);
  logic [31:0]      pc_q, pc_d;
  pipe_entry_t      s2_q, s3_q, s4_q, s2_d, s3_d, s4_d;
  logic             pred_s1, resolve, mispredict;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;
  always_comb begin
    pred_s1    = bus.hit_s1 & bus.p_s1;
    resolve    = s4_q.valid & bus.is_branch_s4 & ~bus.stall;
    mispredict = resolve & ((bus.taken_s4 != s4_q.pred) |
                 (bus.taken_s4 & s4_q.pred & (bus.target_s4 != s4_q.pred_tgt)));
    pc_d = mispredict ? (bus.taken_s4 ? bus.target_s4 : s4_q.pc + PC_INC) :
           bus.stall  ? pc_q :
           pred_s1    ? bus.b_dest_out : pc_q + PC_INC;
    s2_d = bus.stall ? s2_q : '{valid: 1'b1, pc: pc_q, pred: pred_s1, pred_tgt: bus.b_dest_out};
    s3_d = bus.stall ? s3_q : s2_q;
    s4_d = bus.stall ? s4_q : s3_q;
    // a flush only squashes: entries keep their fields, nothing shifts in
    if (mispredict) begin
      s2_d       = s2_q;
      s3_d       = s3_q;
      s4_d       = s4_q;
      s2_d.valid = 1'b0;
      s3_d.valid = 1'b0;
      s4_d.valid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else begin
      pc_q <= pc_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (.clk(clk), .rst(rst), .inc(resolve), .cnt(branch_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (.clk(clk), .rst(rst), .inc(mispredict), .cnt(mispred_cnt));
  assign bus.inst_adress_s1 = pc_q;
  assign bus.inst_adress_s4 = s4_q.pc;
  assign bus.write_rp       = resolve;
  assign bus.write_rt       = resolve & bus.taken_s4;
  assign bus.deviated_s4    = bus.taken_s4;
  assign bus.b_dest_in      = bus.target_s4;
  assign bus.flush          = mispredict;
  assign bus.branch_cnt     = branch_cnt;
  assign bus.mispred_cnt    = mispred_cnt;
endmodule

// File: tb/tb_fetch_pc_predict.sv
// tb_fetch_pc_predict: directed scenarios with a small branch-table/branch-unit environment and expectation queue
module tb_fetch_pc_predict;
  localparam int CNT_W = 2;
  logic clk, rst;
  fetch_pc_predict_if #(.CNT_W(CNT_W)) bus ();
  fetch_pc_predict #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        bt_en, bt_p, br_en, br_any, br_taken;
  logic [31:0] bt_pc, bt_tgt, br_pc, br_tgt;
  always_comb begin
    bus.hit_s1       = bt_en && (bus.inst_adress_s1 == bt_pc);
    bus.p_s1         = bt_p;
    bus.b_dest_out   = bt_tgt;
    bus.is_branch_s4 = br_any || (br_en && (bus.inst_adress_s4 == br_pc));
    bus.taken_s4     = br_taken;
    bus.target_s4    = br_tgt;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic env_clear();
    bus.stall = 1'b0;
    bt_en = 1'b0; bt_p = 1'b0; bt_pc = '0; bt_tgt = '0;
    br_en = 1'b0; br_any = 1'b0; br_taken = 1'b0; br_pc = '0; br_tgt = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    env_clear();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_s4(input logic [31:0] pc);
    for (int i = 0; i < 40 && bus.inst_adress_s4 != pc; i++) tick();
    check("wait_s4", bus.inst_adress_s4, pc);
  endtask

  initial begin
    rst = 1'b1;
    env_clear();
    @(negedge clk);
    // reset, with a branch presented at an invalid s4
    br_en = 1'b1; br_pc = 32'h0; br_taken = 1'b1; br_tgt = 32'h99;
    expect_val("rst_pc", 32'h0);
    expect_val("rst_flush", 32'h0);
    expect_val("rst_bcnt", 32'h0);
    expect_val("rst_mcnt", 32'h0);
    expect_val("inv_s4_wrp", 32'h0);
    tick();
    tick();
    observe(bus.inst_adress_s1);
    observe({31'b0, bus.flush});
    observe({30'b0, bus.branch_cnt});
    observe({30'b0, bus.mispred_cnt});
    observe({31'b0, bus.write_rp});
    rst = 1'b0;
    #1;
    expect_val("inv_s4_flush", 32'h0);
    observe({31'b0, bus.flush});
    br_en = 1'b0;
    // sequential fetch
    for (int i = 1; i <= 4; i++) begin
      expect_val("seq_pc", 32'(i * 4));
      tick();
      observe(bus.inst_adress_s1);
    end
    // predicted taken, resolved taken to the predicted target
    bt_en = 1'b1; bt_p = 1'b1; bt_pc = 32'h10; bt_tgt = 32'h40;
    br_en = 1'b1; br_pc = 32'h10; br_taken = 1'b1; br_tgt = 32'h40;
    expect_val("pred_pc", 32'h40);
    tick();
    observe(bus.inst_adress_s1);
    tick();
    tick();
    expect_val("hit_s4pc", 32'h10);
    expect_val("hit_wrp", 32'h1);
    expect_val("hit_wrt", 32'h1);
    expect_val("hit_flush", 32'h0);
    expect_val("hit_dest_in", 32'h40);
    expect_val("hit_dev", 32'h1);
    expect_val("hit_pc", 32'h48);
    observe(bus.inst_adress_s4);
    observe({31'b0, bus.write_rp});
    observe({31'b0, bus.write_rt});
    observe({31'b0, bus.flush});
    observe(bus.b_dest_in);
    observe({31'b0, bus.deviated_s4});
    observe(bus.inst_adress_s1);
    expect_val("hit_bcnt", 32'h1);
    expect_val("hit_mcnt", 32'h0);
    tick();
    observe({30'b0, bus.branch_cnt});
    observe({30'b0, bus.mispred_cnt});

    // not-predicted branch resolves taken
    do_reset();
    br_en = 1'b1; br_pc = 32'h20; br_taken = 1'b1; br_tgt = 32'h80;
    wait_s4(32'h20);
    expect_val("mp1_pc_before", 32'h2C);
    expect_val("mp1_flush", 32'h1);
    expect_val("mp1_wrt", 32'h1);
    observe(bus.inst_adress_s1);
    observe({31'b0, bus.flush});
    observe({31'b0, bus.write_rt});
    expect_val("mp1_pc", 32'h80);
    expect_val("mp1_mcnt", 32'h1);
    expect_val("mp1_bcnt", 32'h1);
    tick();
    observe(bus.inst_adress_s1);
    observe({30'b0, bus.mispred_cnt});
    observe({30'b0, bus.branch_cnt});
    // squashed entries must never resolve even when flagged as branches
    br_en = 1'b0; br_any = 1'b1; br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_val("squash_wrp", 32'h0);
      observe({31'b0, bus.write_rp});
      tick();
    end
    expect_val("refill_s4pc", 32'h80);
    expect_val("refill_wrp", 32'h1);
    expect_val("refill_flush", 32'h0);
    observe(bus.inst_adress_s4);
    observe({31'b0, bus.write_rp});
    observe({31'b0, bus.flush});

    // predicted taken, resolves not taken
    do_reset();
    bt_en = 1'b1; bt_p = 1'b1; bt_pc = 32'h10; bt_tgt = 32'h40;
    br_en = 1'b1; br_pc = 32'h10; br_taken = 1'b0; br_tgt = 32'h40;
    wait_s4(32'h10);
    expect_val("mp2_flush", 32'h1);
    expect_val("mp2_wrp", 32'h1);
    expect_val("mp2_wrt", 32'h0);
    observe({31'b0, bus.flush});
    observe({31'b0, bus.write_rp});
    observe({31'b0, bus.write_rt});
    expect_val("mp2_pc", 32'h14);
    expect_val("mp2_mcnt", 32'h1);
    tick();
    observe(bus.inst_adress_s1);
    observe({30'b0, bus.mispred_cnt});

    // reset dominates a concurrent flush and stall
    do_reset();
    br_en = 1'b1; br_pc = 32'h20; br_taken = 1'b1; br_tgt = 32'h80;
    wait_s4(32'h20);
    rst = 1'b1;
    bus.stall = 1'b1;
    expect_val("rstdom_pc", 32'h0);
    expect_val("rstdom_mcnt", 32'h0);
    tick();
    observe(bus.inst_adress_s1);
    observe({30'b0, bus.mispred_cnt});
    rst = 1'b0;
    bus.stall = 1'b0;
    #1;
    expect_val("rstdom_flush", 32'h0);
    observe({31'b0, bus.flush});

    // stall while a branch sits in s4, then saturation
    do_reset();
    br_en = 1'b1; br_pc = 32'h10; br_taken = 1'b1; br_tgt = 32'h14;
    wait_s4(32'h10);
    bus.stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_val("stall_wrp", 32'h0);
      expect_val("stall_flush", 32'h0);
      expect_val("stall_pc", 32'h1C);
      expect_val("stall_bcnt", 32'h0);
      observe({31'b0, bus.write_rp});
      observe({31'b0, bus.flush});
      observe(bus.inst_adress_s1);
      observe({30'b0, bus.branch_cnt});
      if (i < 2) tick();
    end
    bus.stall = 1'b0;
    #1;
    expect_val("unstall_wrp", 32'h1);
    expect_val("unstall_flush", 32'h1);
    observe({31'b0, bus.write_rp});
    observe({31'b0, bus.flush});
    expect_val("unstall_pc", 32'h14);
    expect_val("unstall_bcnt", 32'h1);
    expect_val("unstall_wrp_after", 32'h0);
    tick();
    observe(bus.inst_adress_s1);
    observe({30'b0, bus.branch_cnt});
    observe({31'b0, bus.write_rp});
    br_en = 1'b0; br_any = 1'b1; br_taken = 1'b0;
    repeat (8) tick();
    expect_val("sat_bcnt", 32'h3);
    expect_val("sat_mcnt", 32'h1);
    observe({30'b0, bus.branch_cnt});
    observe({30'b0, bus.mispred_cnt});

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
